// File: rtl/v_issue_pkg.sv
// Shared types and opcode constants for the vector instruction issue queue.
package v_issue_pkg;

    localparam logic [6:0] V_LOAD_OPCODE  = 7'b0000111;
    localparam logic [6:0] V_STORE_OPCODE = 7'b0100111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } v_issue_entry_t;

    localparam int unsigned ENTRY_W = $bits(v_issue_entry_t);

endpackage

// File: rtl/v_issue_fifo_mem.sv
// DEPTH x entry register array: synchronous write, asynchronous read; contents are not reset.
module v_issue_fifo_mem
    import v_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  v_issue_entry_t wdata,
    input  logic [AW-1:0]  raddr,
    output v_issue_entry_t rdata
);

    v_issue_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/v_instr_issue_queue.sv
// In-order issue FIFO between scalar and vector cores, with outstanding
// vector load/store tracking and a sticky done-pulse underflow flag.
module v_instr_issue_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 15,
    parameter logic [6:0]  V_LOAD_OPCODE   = v_issue_pkg::V_LOAD_OPCODE,
    parameter logic [6:0]  V_STORE_OPCODE  = v_issue_pkg::V_STORE_OPCODE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] v_instruction_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        v_valid_o,
    input  logic        v_ready_i,
    output logic [31:0] vector_instr_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    input  logic        v_load_done_i,
    input  logic        v_store_done_i,
    output logic        all_v_loads_executed_o,
    output logic        all_v_stores_executed_o,
    output logic        vector_stall_o,
    output logic        err_o
);

    import v_issue_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_d;
    logic [OW-1:0]  ld_cnt, ld_cnt_d;
    logic [OW-1:0]  st_cnt, st_cnt_d;
    logic           err_d;

    logic           is_ld, is_st;
    logic           full, empty;
    logic           ld_limit, st_limit;
    logic           push, pop;
    logic           ld_inc, ld_dec, st_inc, st_dec;

    v_issue_entry_t wr_entry, rd_entry;

    // Opcode classification of the instruction being offered
    assign is_ld = (v_instruction_i[6:0] == V_LOAD_OPCODE);
    assign is_st = (v_instruction_i[6:0] == V_STORE_OPCODE);

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign ld_limit = (ld_cnt == OW'(MAX_OUTSTANDING));
    assign st_limit = (st_cnt == OW'(MAX_OUTSTANDING));

    // Acceptance is purely from registered state plus opcode; no v_ready_i path
    assign s_ready_o = !full && !(is_ld && ld_limit) && !(is_st && st_limit);
    assign push      = s_valid_i && s_ready_o;
    assign v_valid_o = !empty;
    assign pop       = v_valid_o && v_ready_i;

    assign wr_entry = '{instr: v_instruction_i, rs1: rs1_i, rs2: rs2_i};

    v_issue_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Head outputs read as zero while empty since the array is never cleared
    assign vector_instr_o = empty ? 32'h0 : rd_entry.instr;
    assign rs1_o          = empty ? 32'h0 : rd_entry.rs1;
    assign rs2_o          = empty ? 32'h0 : rd_entry.rs2;

    assign vector_stall_o          = full;
    assign all_v_loads_executed_o  = (ld_cnt == '0);
    assign all_v_stores_executed_o = (st_cnt == '0);

    // Next-state for fill level and outstanding counters
    always_comb begin
        count_d  = count;
        ld_cnt_d = ld_cnt;
        st_cnt_d = st_cnt;
        err_d    = err_o;

        ld_inc = push && is_ld;
        st_inc = push && is_st;
        ld_dec = v_load_done_i && (ld_cnt != '0);
        st_dec = v_store_done_i && (st_cnt != '0);

        case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase

        if (ld_inc && !ld_dec) begin
            ld_cnt_d = ld_cnt + OW'(1);
        end else if (!ld_inc && ld_dec) begin
            ld_cnt_d = ld_cnt - OW'(1);
        end

        if (st_inc && !st_dec) begin
            st_cnt_d = st_cnt + OW'(1);
        end else if (!st_inc && st_dec) begin
            st_cnt_d = st_cnt - OW'(1);
        end

        // A retire pulse with nothing pending is a protocol violation
        if ((v_load_done_i && (ld_cnt == '0)) || (v_store_done_i && (st_cnt == '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ld_cnt <= '0;
            st_cnt <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_d;
            ld_cnt <= ld_cnt_d;
            st_cnt <= st_cnt_d;
            err_o  <= err_d;
        end
    end

endmodule

// File: tb/tb_v_instr_issue_queue.sv
// Scoreboard bench for v_instr_issue_queue: a reference model tracks fill level,
// outstanding counters and the error flag; queued entries are checked at the head.
module tb_v_instr_issue_queue;
    import v_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] v_instruction_i, rs1_i, rs2_i;
    logic        v_valid_o;
    logic        v_ready_i;
    logic [31:0] vector_instr_o, rs1_o, rs2_o;
    logic        v_load_done_i, v_store_done_i;
    logic        all_v_loads_executed_o, all_v_stores_executed_o;
    logic        vector_stall_o, err_o;

    int passed = 0;
    int total  = 0;

    int m_count = 0;
    int m_ld    = 0;
    int m_st    = 0;
    logic m_err = 1'b0;
    v_issue_entry_t sb[$];

    v_instr_issue_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .s_valid_i               (s_valid_i),
        .s_ready_o               (s_ready_o),
        .v_instruction_i         (v_instruction_i),
        .rs1_i                   (rs1_i),
        .rs2_i                   (rs2_i),
        .v_valid_o               (v_valid_o),
        .v_ready_i               (v_ready_i),
        .vector_instr_o          (vector_instr_o),
        .rs1_o                   (rs1_o),
        .rs2_o                   (rs2_o),
        .v_load_done_i           (v_load_done_i),
        .v_store_done_i          (v_store_done_i),
        .all_v_loads_executed_o  (all_v_loads_executed_o),
        .all_v_stores_executed_o (all_v_stores_executed_o),
        .vector_stall_o          (vector_stall_o),
        .err_o                   (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic sv, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic vr, input logic ldd, input logic std);
        s_valid_i       = sv;
        v_instruction_i = ins;
        rs1_i           = r1;
        rs2_i           = r2;
        v_ready_i       = vr;
        v_load_done_i   = ldd;
        v_store_done_i  = std;
        #1;
    endtask

    // Advance the reference model with the current inputs, then clock one cycle
    task automatic tick();
        logic isl, iss, push, pop;
        int ld_old, st_old;
        isl = (v_instruction_i[6:0] == 7'b0000111);
        iss = (v_instruction_i[6:0] == 7'b0100111);
        if (!rstn) begin
            m_count = 0; m_ld = 0; m_st = 0; m_err = 1'b0;
            sb.delete();
        end else begin
            ld_old = m_ld;
            st_old = m_st;
            push = s_valid_i && (m_count != DEPTH) && !(isl && m_ld == MAXO) && !(iss && m_st == MAXO);
            pop  = (m_count != 0) && v_ready_i;
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back('{instr: v_instruction_i, rs1: rs1_i, rs2: rs2_i});
            m_count = m_count + int'(push) - int'(pop);
            if (push && isl) m_ld++;
            if (push && iss) m_st++;
            if (v_load_done_i) begin
                if (ld_old == 0) m_err = 1'b1; else m_ld--;
            end
            if (v_store_done_i) begin
                if (st_old == 0) m_err = 1'b1; else m_st--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        tick(); tick();
        rstn = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++;
        if ({s_ready_o, v_valid_o, all_v_loads_executed_o, all_v_stores_executed_o, vector_stall_o, err_o} !== 6'b101100)
            $display("FAIL reset_flags: got %b want 101100",
                     {s_ready_o, v_valid_o, all_v_loads_executed_o, all_v_stores_executed_o, vector_stall_o, err_o});
        else passed++;
        total++;
        if ({vector_instr_o, rs1_o, rs2_o} !== 96'h0)
            $display("FAIL reset_head: got %h %h %h want zeros", vector_instr_o, rs1_o, rs2_o);
        else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h57 | (i << 20), 32'h1000 + i, 32'h2000 + i, 0, 0, 0);
            total++;
            if (s_ready_o !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", i, s_ready_o);
            else passed++;
            tick();
        end
        drive(1, 32'h0040_0057, 32'h1004, 32'h2004, 0, 0, 0);
        total++;
        if ({s_ready_o, vector_stall_o, v_valid_o} !== 3'b011)
            $display("FAIL fill_full: ready/stall/valid got %b want 011", {s_ready_o, vector_stall_o, v_valid_o});
        else passed++;
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++;
        if (vector_stall_o !== 1'b1 || m_count != DEPTH)
            $display("FAIL fill_refused: stall got %b want 1 (model count %0d)", vector_stall_o, m_count);
        else passed++;
    endtask

    task automatic test_drain();
        logic [31:0] exp_i [4];
        exp_i[0] = 32'h0000_0057; exp_i[1] = 32'h0010_0057;
        exp_i[2] = 32'h0020_0057; exp_i[3] = 32'h0030_0057;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
            total++;
            if (sb.size() == 0) $display("FAIL drain_sb[%0d]: scoreboard empty, want entry", i);
            else if (v_valid_o !== 1'b1 || vector_instr_o !== sb[0].instr || rs1_o !== sb[0].rs1 ||
                     rs2_o !== sb[0].rs2 || vector_instr_o !== exp_i[i])
                $display("FAIL drain_head[%0d]: got v=%b %h %h %h want %h %h %h", i, v_valid_o,
                         vector_instr_o, rs1_o, rs2_o, exp_i[i], sb[0].rs1, sb[0].rs2);
            else passed++;
            tick();
        end
        drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        total++;
        if (v_valid_o !== 1'b0 || vector_instr_o !== 32'h0)
            $display("FAIL drain_empty: valid=%b instr=%h want 0 0", v_valid_o, vector_instr_o);
        else passed++;
    endtask

    task automatic test_streaming();
        int errs = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h0A00_0057 + (i << 12), 32'hA000 + i, 32'hB000 + i, 0, 0, 0);
            tick();
        end
        for (int i = 2; i < 22; i++) begin
            drive(1, 32'h0A00_0057 + (i << 12), 32'hA000 + i, 32'hB000 + i, 1, 0, 0);
            if (sb.size() == 0 || v_valid_o !== 1'b1 || s_ready_o !== 1'b1 || vector_stall_o !== 1'b0 ||
                vector_instr_o !== sb[0].instr || rs1_o !== sb[0].rs1 || rs2_o !== sb[0].rs2) errs++;
            tick();
        end
        total++;
        if (errs != 0) $display("FAIL stream_head: %0d bad cycles want 0", errs);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
            total++;
            if (sb.size() == 0 || v_valid_o !== 1'b1 || vector_instr_o !== sb[0].instr || rs1_o !== sb[0].rs1)
                $display("FAIL stream_tail[%0d]: got v=%b %h want %h", i, v_valid_o, vector_instr_o,
                         (sb.size() != 0) ? sb[0].instr : 32'hx);
            else passed++;
            tick();
        end
        drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        total++;
        if (v_valid_o !== 1'b0) $display("FAIL stream_empty: valid got %b want 0", v_valid_o);
        else passed++;
    endtask

    task automatic test_loads();
        drive(1, 32'h0200_0007, 32'h11, 32'h22, 1, 0, 0);
        total++;
        if (all_v_loads_executed_o !== 1'b1) $display("FAIL ld_before: got %b want 1", all_v_loads_executed_o);
        else passed++;
        tick();
        drive(1, 32'h0200_1007, 32'h33, 32'h44, 1, 1, 0);
        total++;
        if (all_v_loads_executed_o !== 1'b0 || m_ld != 1)
            $display("FAIL ld_pending: got %b want 0", all_v_loads_executed_o);
        else passed++;
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        total++;
        if (all_v_loads_executed_o !== (m_ld == 0) || m_ld != 1)
            $display("FAIL ld_same_cycle: got %b want 0 (model ld %0d)", all_v_loads_executed_o, m_ld);
        else passed++;
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        total++;
        if (all_v_loads_executed_o !== 1'b1 || err_o !== 1'b0)
            $display("FAIL ld_retired: all_ld=%b err=%b want 1 0", all_v_loads_executed_o, err_o);
        else passed++;
    endtask

    task automatic test_store_limit();
        for (int i = 0; i < MAXO; i++) begin
            drive(1, 32'h0300_0027 + (i << 12), 32'h500 + i, 32'h600 + i, 1, 0, 0);
            tick();
        end
        drive(1, 32'h0300_F027, 32'h5FF, 32'h6FF, 1, 0, 0);
        total++;
        if (s_ready_o !== 1'b0 || all_v_stores_executed_o !== 1'b0)
            $display("FAIL st_limit: ready=%b all_st=%b want 0 0", s_ready_o, all_v_stores_executed_o);
        else passed++;
        drive(1, 32'h0000_0057, 32'h77, 32'h88, 1, 0, 0);
        total++;
        if (s_ready_o !== 1'b1) $display("FAIL st_limit_other: ready got %b want 1", s_ready_o);
        else passed++;
        tick();
        for (int i = 0; i < MAXO; i++) begin
            drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 1);
            tick();
        end
        drive(0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        total++;
        if (all_v_stores_executed_o !== 1'b1 || err_o !== 1'b0 || v_valid_o !== 1'b0)
            $display("FAIL st_retired: all_st=%b err=%b valid=%b want 1 0 0",
                     all_v_stores_executed_o, err_o, v_valid_o);
        else passed++;
    endtask

    task automatic test_underflow();
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++;
        if (err_o !== m_err || err_o !== 1'b1 || all_v_stores_executed_o !== 1'b1)
            $display("FAIL underflow: err=%b all_st=%b want 1 1", err_o, all_v_stores_executed_o);
        else passed++;
        tick(); tick();
        total++;
        if (err_o !== 1'b1) $display("FAIL underflow_sticky: err got %b want 1", err_o);
        else passed++;
    endtask

    task automatic test_midreset();
        drive(1, 32'h0400_0007, 32'h1, 32'h2, 0, 0, 0); tick();
        drive(1, 32'h0400_1007, 32'h3, 32'h4, 0, 0, 0); tick();
        drive(1, 32'h0400_2057, 32'h5, 32'h6, 0, 0, 0); tick();
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++;
        if (v_valid_o !== 1'b1 || all_v_loads_executed_o !== 1'b0 || m_ld != 2 || m_count != 3 ||
            vector_instr_o !== 32'h0400_0007)
            $display("FAIL pre_reset: valid=%b all_ld=%b head=%h want 1 0 04000007",
                     v_valid_o, all_v_loads_executed_o, vector_instr_o);
        else passed++;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++;
        if ({s_ready_o, v_valid_o, all_v_loads_executed_o, all_v_stores_executed_o, vector_stall_o, err_o} !== 6'b101100 ||
            vector_instr_o !== 32'h0)
            $display("FAIL midreset: flags got %b want 101100 head=%h",
                     {s_ready_o, v_valid_o, all_v_loads_executed_o, all_v_stores_executed_o, vector_stall_o, err_o},
                     vector_instr_o);
        else passed++;
        tick();
        total++;
        if (v_valid_o !== 1'b0) $display("FAIL midreset_next: valid got %b want 0", v_valid_o);
        else passed++;
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_loads();
        test_store_limit();
        test_underflow();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
